// File: rtl/mux_rr_scanner.sv
// Round-robin request scanner driving the select of a 4:1 mux.
// It waits a settle time, then samples the mux output y and presents it on a valid/ready port.
module mux_rr_scanner #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       y,
  output logic [1:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_data,
  output logic [1:0] out_ch,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);

  state_t     state, state_n;
  logic [1:0] sel_n, last, last_n, out_ch_n;
  logic [3:0] cnt, cnt_n;
  logic       out_valid_n, out_data_n;
  logic [1:0] grant, idx;
  logic       found;

  // Search order starts one past the last delivered channel and wraps mod 4.
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    cnt_n       = cnt;
    last_n      = last;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_ch_n    = out_ch;
    unique case (state)
      IDLE: begin
        if (en && (|req)) begin
          sel_n   = grant;
          cnt_n   = CNT_INIT;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          out_data_n  = y;
          out_ch_n    = sel;
          out_valid_n = 1'b1;
          state_n     = VALID;
        end
      end
      VALID: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          last_n      = out_ch;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      last      <= 2'd3;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_ch    <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      last      <= last_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_ch    <= out_ch_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_scanner.sv
// Scoreboard bench for mux_rr_scanner with a behavioural 4:1 mux on y.
// Stimulus pushes expected {data,ch}; the monitor pops on every handshake.
module tb_mux_rr_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       y;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic       out_data;
  logic [1:0] out_ch;
  logic       busy;
  logic [3:0] i_vec;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int cyc = 0;
  int sid = 0;
  logic [2:0] exp_q[$];

  mux_rr_scanner #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .y(y), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .busy(busy)
  );

  assign y = i_vec[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake happens on the next rising edge when valid & ready at negedge.
  initial begin
    int prev_cyc = 0;
    int prev_sid = -1;
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(e[2]));
          chk("out_ch", int'(out_ch), int'(e[1:0]));
        end
        if (prev_sid == sid) chk("period", cyc - prev_cyc, 4);
        prev_sid = sid;
        prev_cyc = cyc;
        hs_count++;
      end
    end
  end

  task automatic wait_hs(input int target);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #1;
      if (hs_count >= target) ok = 1'b1;
    end
    if (!ok) chk("hs_timeout", hs_count, target);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic stream(input logic [3:0] reqv, input int n);
    int target;
    target = hs_count + n;
    sid++;
    en = 1'b1;
    req = reqv;
    out_ready = 1'b1;
    wait_hs(target);
    en = 1'b0;
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0; i_vec = 4'b1010;
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ch", int'(out_ch), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Backpressure on ch2 (first scan from last=3 reaches 2); y toggles must not leak.
    @(posedge clk); #1;
    en = 1'b1; req = 4'b0100; out_ready = 1'b0;
    exp_q.push_back({1'b0, 2'd2});
    @(posedge clk); #1;
    en = 1'b0; req = '0;
    chk("bp_grant_sel", int'(sel), 2);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      i_vec = ~i_vec;
      @(posedge clk); #1;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 0);
      chk("bp_ch", int'(out_ch), 2);
      chk("bp_sel", int'(sel), 2);
    end
    i_vec = 4'b1010;
    out_ready = 1'b1;
    sid++;
    wait_hs(1);
    out_ready = 1'b0;

    // last=2: req=0001 grants ch0; reset mid-VALID discards it.
    @(posedge clk); #1;
    en = 1'b1; req = 4'b0001;
    @(posedge clk); #1;
    en = 1'b0; req = '0;
    chk("r_grant_sel", int'(sel), 0);
    wait_valid();
    #1 rst_n = 1'b0;
    #1;
    chk("amid_valid", int'(out_valid), 0);
    chk("amid_sel", int'(sel), 0);
    chk("amid_busy", int'(busy), 0);
    chk("amid_ch", int'(out_ch), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset last=3: req=1000 grants ch3 (i3=1).
    exp_q.push_back({1'b1, 2'd3});
    stream(4'b1000, 1);

    // Full round robin from last=3.
    exp_q.push_back({1'b0, 2'd0});
    exp_q.push_back({1'b1, 2'd1});
    exp_q.push_back({1'b0, 2'd2});
    exp_q.push_back({1'b1, 2'd3});
    exp_q.push_back({1'b0, 2'd0});
    stream(4'b1111, 5);

    // last=0: req=1001 alternates 3,0,3,0.
    exp_q.push_back({1'b1, 2'd3});
    exp_q.push_back({1'b0, 2'd0});
    exp_q.push_back({1'b1, 2'd3});
    exp_q.push_back({1'b0, 2'd0});
    stream(4'b1001, 4);

    // Single persistent requester is granted every scan.
    exp_q.push_back({1'b0, 2'd2});
    exp_q.push_back({1'b0, 2'd2});
    exp_q.push_back({1'b0, 2'd2});
    stream(4'b0100, 3);

    // Latency plus mid-flight drop of en/req (last=2 -> req=0010 grants ch1).
    sid++;
    @(posedge clk); #1;
    en = 1'b1; req = 4'b0010; out_ready = 1'b1;
    exp_q.push_back({1'b1, 2'd1});
    @(posedge clk); #1;
    chk("lat_sel", int'(sel), 1);
    chk("lat_busy", int'(busy), 1);
    chk("lat_valid0", int'(out_valid), 0);
    en = 1'b0; req = '0;
    @(posedge clk); #1;
    chk("lat_valid1", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_valid2", int'(out_valid), 1);
    chk("lat_data", int'(out_data), 1);
    chk("lat_ch", int'(out_ch), 1);
    @(posedge clk); #1;
    chk("drop_valid", int'(out_valid), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("drop_busy", int'(busy), 0);
    end

    chk("sb_left", exp_q.size(), 0);
    chk("hs_total", hs_count, 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
